// File: rtl/muldiv_ctrl.sv
// HI/LO write sequencer: iterative multiply (MUL_LAT cycles) and restoring divide
// (one bit per cycle), plus single-cycle MTHI/MTLO, with pipeline stall generation.
module muldiv_ctrl #(
  parameter int DATA_W  = 32,
  parameter int MUL_LAT = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              op_valid,
  input  logic [2:0]        op_type,
  input  logic [DATA_W-1:0] src_a,
  input  logic [DATA_W-1:0] src_b,
  input  logic              read_req,
  input  logic              flush,
  output logic              stall_req,
  output logic              busy,
  output logic              writeHi,
  output logic              writeLo,
  output logic [DATA_W-1:0] hi_data_out,
  output logic [DATA_W-1:0] lo_data_out
);

  localparam int CNT_MAX = (DATA_W > MUL_LAT) ? DATA_W : MUL_LAT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_e;

  state_e              state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [DATA_W-1:0]   a_q, b_q;
  logic                sgn_q, qneg_q, rneg_q, dz_q;
  logic [DATA_W-1:0]   quo_q, rem_q, dvs_q;
  logic [DATA_W-1:0]   hi_q, lo_q;

  logic                is_mul, is_div, accept, sgn_in, arith_busy;
  logic [DATA_W-1:0]   abs_a, abs_b;
  logic [2*DATA_W-1:0] ext_a, ext_b, prod;
  logic [DATA_W:0]     rem_sh, diff;
  logic [DATA_W-1:0]   rem_d, quo_d;

  always_comb begin
    is_mul     = (op_type == 3'b000) || (op_type == 3'b001);
    is_div     = (op_type == 3'b010) || (op_type == 3'b011);
    sgn_in     = ~op_type[0];
    accept     = !reset && !flush && (state_q == S_IDLE) && op_valid;
    arith_busy = (state_q == S_MUL) || (state_q == S_DIV) || (state_q == S_FIX);
    abs_a      = (sgn_in && src_a[DATA_W-1]) ? -src_a : src_a;
    abs_b      = (sgn_in && src_b[DATA_W-1]) ? -src_b : src_b;
    // Sign-extend to full product width so one unsigned multiply serves MULT and MULTU.
    ext_a      = {{DATA_W{sgn_q & a_q[DATA_W-1]}}, a_q};
    ext_b      = {{DATA_W{sgn_q & b_q[DATA_W-1]}}, b_q};
    prod       = ext_a * ext_b;
    rem_sh     = {rem_q, quo_q[DATA_W-1]};
    diff       = rem_sh - {1'b0, dvs_q};
    rem_d      = diff[DATA_W] ? rem_sh[DATA_W-1:0] : diff[DATA_W-1:0];
    quo_d      = {quo_q[DATA_W-2:0], ~diff[DATA_W]};
  end

  always_comb begin
    stall_req   = !reset && !flush &&
                  ((state_q == S_IDLE && op_valid && (is_mul || is_div)) ||
                   arith_busy || (read_req && arith_busy));
    busy        = !reset && (state_q != S_IDLE);
    writeHi     = !reset && !flush &&
                  ((state_q == S_IDLE && op_valid && op_type == 3'b100) || state_q == S_DONE);
    writeLo     = !reset && !flush &&
                  ((state_q == S_IDLE && op_valid && op_type == 3'b101) || state_q == S_DONE);
    hi_data_out = '0;
    lo_data_out = '0;
    if (writeHi) hi_data_out = (state_q == S_DONE) ? hi_q : src_a;
    if (writeLo) lo_data_out = (state_q == S_DONE) ? lo_q : src_a;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sgn_q   <= 1'b0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      dz_q    <= 1'b0;
      quo_q   <= '0;
      rem_q   <= '0;
      dvs_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else if (flush) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          cnt_q <= '0;
          if (accept && is_mul) begin
            a_q     <= src_a;
            b_q     <= src_b;
            sgn_q   <= sgn_in;
            state_q <= S_MUL;
          end else if (accept && is_div) begin
            a_q     <= src_a;
            quo_q   <= abs_a;
            dvs_q   <= abs_b;
            rem_q   <= '0;
            qneg_q  <= sgn_in & (src_a[DATA_W-1] ^ src_b[DATA_W-1]);
            rneg_q  <= sgn_in & src_a[DATA_W-1];
            dz_q    <= (src_b == '0);
            state_q <= S_DIV;
          end
        end
        S_MUL: begin
          if (cnt_q == CNT_W'(MUL_LAT - 1)) begin
            {hi_q, lo_q} <= prod;
            cnt_q        <= '0;
            state_q      <= S_DONE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_DIV: begin
          quo_q <= quo_d;
          rem_q <= rem_d;
          if (cnt_q == CNT_W'(DATA_W - 1)) begin
            cnt_q   <= '0;
            state_q <= S_FIX;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_FIX: begin
          // Divide-by-zero returns the raw dividend in HI regardless of signedness.
          if (dz_q) begin
            hi_q <= a_q;
            lo_q <= '1;
          end else begin
            hi_q <= rneg_q ? -rem_q : rem_q;
            lo_q <= qneg_q ? -quo_q : quo_q;
          end
          state_q <= S_DONE;
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl: MT*, multiply, divide corner cases, flush, reset and hazards.
module tb_muldiv_ctrl;

  localparam logic [2:0] OP_MULT = 3'b000, OP_MULTU = 3'b001, OP_DIV = 3'b010,
                         OP_DIVU = 3'b011, OP_MTHI = 3'b100, OP_MTLO = 3'b101;

  logic        clock = 1'b0;
  logic        reset, op_valid, read_req, flush;
  logic [2:0]  op_type;
  logic [31:0] src_a, src_b;
  logic        stall_req, busy, writeHi, writeLo;
  logic [31:0] hi_data_out, lo_data_out;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clock = ~clock;

  muldiv_ctrl #(.DATA_W(32), .MUL_LAT(2)) dut (
    .clock(clock), .reset(reset), .op_valid(op_valid), .op_type(op_type),
    .src_a(src_a), .src_b(src_b), .read_req(read_req), .flush(flush),
    .stall_req(stall_req), .busy(busy), .writeHi(writeHi), .writeLo(writeLo),
    .hi_data_out(hi_data_out), .lo_data_out(lo_data_out)
  );

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic idle_in;
    op_valid = 1'b0; op_type = 3'b000; src_a = '0; src_b = '0;
    read_req = 1'b0; flush = 1'b0;
  endtask

  // Presents an op (held while stalled) and measures cycles to the dual write.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] hi, output logic [31:0] lo,
                        output int lat, output int stl, output logic dstall);
    op_valid = 1'b1; op_type = op; src_a = a; src_b = b;
    lat = -1; stl = 0; hi = 'x; lo = 'x; dstall = 1'b1;
    for (int c = 0; c < 60; c++) begin
      @(negedge clock);
      if (writeHi && writeLo) begin
        hi = hi_data_out; lo = lo_data_out; lat = c; dstall = stall_req;
        break;
      end
      if (stall_req) stl++;
      tick();
    end
    tick();
    idle_in();
  endtask

  task automatic test_reset;
    reset = 1'b1; idle_in();
    op_valid = 1'b1; op_type = OP_MTHI; src_a = 32'h5;
    tick(); tick();
    @(negedge clock);
    n_tests++;
    if ({busy, stall_req, writeHi, writeLo} !== 4'b0 || hi_data_out !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_outputs got busy=%b stall=%b wh=%b wl=%b hi=%h exp all 0",
               busy, stall_req, writeHi, writeLo, hi_data_out);
    end
    tick();
    reset = 1'b0; idle_in();
  endtask

  task automatic test_mt;
    op_valid = 1'b1; op_type = OP_MTHI; src_a = 32'h12345678;
    @(negedge clock);
    n_tests++;
    if ({writeHi, writeLo, stall_req} !== 3'b100 || hi_data_out !== 32'h12345678) begin
      n_fail++;
      $display("FAIL mthi got wh=%b wl=%b stall=%b hi=%h exp 1 0 0 12345678",
               writeHi, writeLo, stall_req, hi_data_out);
    end
    tick();
    idle_in();
    @(negedge clock);
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL mthi_busy got %b exp 0", busy);
    end
    tick();
  endtask

  task automatic test_mult;
    logic [31:0] hi, lo; int lat, stl; logic ds;
    run_op(OP_MULT, 32'hFFFFFFFD, 32'd5, hi, lo, lat, stl, ds);
    n_tests++;
    if (lat !== 3 || stl !== 3 || ds !== 1'b0) begin
      n_fail++; $display("FAIL mult_timing got lat=%0d stalls=%0d done_stall=%b exp 3 3 0", lat, stl, ds);
    end
    n_tests++;
    if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFF1) begin
      n_fail++; $display("FAIL mult_data got %h_%h exp ffffffff_fffffff1", hi, lo);
    end
    run_op(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, hi, lo, lat, stl, ds);
    n_tests++;
    if (lat !== 3 || hi !== 32'hFFFFFFFE || lo !== 32'h00000001) begin
      n_fail++; $display("FAIL multu got lat=%0d %h_%h exp 3 fffffffe_00000001", lat, hi, lo);
    end
  endtask

  task automatic test_div;
    logic [31:0] hi, lo; int lat, stl; logic ds;
    run_op(OP_DIV, 32'hFFFFFFF9, 32'd2, hi, lo, lat, stl, ds);
    n_tests++;
    if (lat !== 34 || stl !== 34 || ds !== 1'b0) begin
      n_fail++; $display("FAIL div_timing got lat=%0d stalls=%0d done_stall=%b exp 34 34 0", lat, stl, ds);
    end
    n_tests++;
    if (lo !== 32'hFFFFFFFD || hi !== 32'hFFFFFFFF) begin
      n_fail++; $display("FAIL div_neg got lo=%h hi=%h exp fffffffd ffffffff", lo, hi);
    end
    run_op(OP_DIV, 32'd7, 32'hFFFFFFFE, hi, lo, lat, stl, ds);
    n_tests++;
    if (lo !== 32'hFFFFFFFD || hi !== 32'h1) begin
      n_fail++; $display("FAIL div_negdivisor got lo=%h hi=%h exp fffffffd 00000001", lo, hi);
    end
    run_op(OP_DIVU, 32'd100, 32'd7, hi, lo, lat, stl, ds);
    n_tests++;
    if (lo !== 32'd14 || hi !== 32'd2) begin
      n_fail++; $display("FAIL divu got lo=%h hi=%h exp 0000000e 00000002", lo, hi);
    end
    run_op(OP_DIV, 32'h80000000, 32'hFFFFFFFF, hi, lo, lat, stl, ds);
    n_tests++;
    if (lo !== 32'h80000000 || hi !== 32'h0) begin
      n_fail++; $display("FAIL div_overflow got lo=%h hi=%h exp 80000000 00000000", lo, hi);
    end
    run_op(OP_DIVU, 32'h1234, 32'h0, hi, lo, lat, stl, ds);
    n_tests++;
    if (lo !== 32'hFFFFFFFF || hi !== 32'h1234) begin
      n_fail++; $display("FAIL divu_zero got lo=%h hi=%h exp ffffffff 00001234", lo, hi);
    end
    run_op(OP_DIV, 32'hFFFFFFF0, 32'h0, hi, lo, lat, stl, ds);
    n_tests++;
    if (lo !== 32'hFFFFFFFF || hi !== 32'hFFFFFFF0) begin
      n_fail++; $display("FAIL div_zero got lo=%h hi=%h exp ffffffff fffffff0", lo, hi);
    end
  endtask

  task automatic test_flush;
    int strobes = 0;
    op_valid = 1'b1; op_type = OP_DIV; src_a = 32'd100; src_b = 32'd7;
    for (int c = 0; c < 10; c++) begin
      @(negedge clock);
      if (writeHi || writeLo) strobes++;
      tick();
    end
    flush = 1'b1;
    @(negedge clock);
    if (writeHi || writeLo) strobes++;
    n_tests++;
    if (strobes !== 0 || stall_req !== 1'b0) begin
      n_fail++; $display("FAIL flush_cycle got strobes=%0d stall=%b exp 0 0", strobes, stall_req);
    end
    tick();
    flush = 1'b0; op_type = OP_MTLO; src_a = 32'hA5A5A5A5;
    @(negedge clock);
    n_tests++;
    if ({writeLo, writeHi, stall_req, busy} !== 4'b1000 || lo_data_out !== 32'hA5A5A5A5) begin
      n_fail++;
      $display("FAIL flush_mtlo got wl=%b wh=%b stall=%b busy=%b lo=%h exp 1 0 0 0 a5a5a5a5",
               writeLo, writeHi, stall_req, busy, lo_data_out);
    end
    tick();
    idle_in();
  endtask

  task automatic test_read_hazard;
    int stl = 0, lat = -1;
    op_valid = 1'b1; op_type = OP_MULT; src_a = 32'd3; src_b = 32'd4;
    tick();
    op_valid = 1'b0; read_req = 1'b1;
    for (int c = 1; c < 10; c++) begin
      @(negedge clock);
      if (writeHi && writeLo) begin
        lat = c;
        n_tests++;
        if (stall_req !== 1'b0 || hi_data_out !== 32'h0 || lo_data_out !== 32'd12) begin
          n_fail++;
          $display("FAIL read_done got stall=%b hi=%h lo=%h exp 0 00000000 0000000c",
                   stall_req, hi_data_out, lo_data_out);
        end
        break;
      end
      if (stall_req) stl++;
      tick();
    end
    n_tests++;
    if (lat !== 3 || stl !== 2) begin
      n_fail++; $display("FAIL read_stall got lat=%0d stalls=%0d exp 3 2", lat, stl);
    end
    tick();
    idle_in();
  endtask

  task automatic test_reset_mid;
    int strobes = 0;
    op_valid = 1'b1; op_type = OP_DIVU; src_a = 32'd50; src_b = 32'd3;
    for (int c = 0; c < 5; c++) begin
      @(negedge clock);
      if (writeHi || writeLo) strobes++;
      tick();
    end
    reset = 1'b1;
    @(negedge clock);
    n_tests++;
    if ({busy, stall_req, writeHi, writeLo} !== 4'b0) begin
      n_fail++; $display("FAIL reset_mid_outputs got busy=%b stall=%b wh=%b wl=%b exp 0",
                         busy, stall_req, writeHi, writeLo);
    end
    tick();
    reset = 1'b0; idle_in();
    @(negedge clock);
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_mid_busy got %b exp 0", busy);
    end
    for (int c = 0; c < 40; c++) begin
      if (writeHi || writeLo) strobes++;
      tick();
      @(negedge clock);
    end
    n_tests++;
    if (strobes !== 0) begin
      n_fail++; $display("FAIL reset_mid_strobes got %0d exp 0", strobes);
    end
    tick();
  endtask

  task automatic test_ignored_op;
    op_valid = 1'b1; op_type = 3'b110; src_a = 32'hDEAD; src_b = 32'h1;
    @(negedge clock);
    n_tests++;
    if ({stall_req, writeHi, writeLo} !== 3'b0) begin
      n_fail++; $display("FAIL op110 got stall=%b wh=%b wl=%b exp 0", stall_req, writeHi, writeLo);
    end
    tick();
    op_type = 3'b111;
    @(negedge clock);
    n_tests++;
    if ({busy, stall_req, writeHi, writeLo} !== 4'b0) begin
      n_fail++; $display("FAIL op111 got busy=%b stall=%b wh=%b wl=%b exp 0",
                         busy, stall_req, writeHi, writeLo);
    end
    tick();
    idle_in();
  endtask

  task automatic test_back_to_back;
    logic [31:0] hi, lo; int lat, stl; logic ds;
    run_op(OP_MULTU, 32'd6, 32'd7, hi, lo, lat, stl, ds);
    n_tests++;
    if (lat !== 3 || hi !== 32'h0 || lo !== 32'd42) begin
      n_fail++; $display("FAIL b2b_mul got lat=%0d %h_%h exp 3 00000000_0000002a", lat, hi, lo);
    end
    run_op(OP_DIVU, 32'hFFFFFFFF, 32'h10, hi, lo, lat, stl, ds);
    n_tests++;
    if (lat !== 34 || lo !== 32'h0FFFFFFF || hi !== 32'hF) begin
      n_fail++; $display("FAIL b2b_div got lat=%0d lo=%h hi=%h exp 34 0fffffff 0000000f", lat, lo, hi);
    end
  endtask

  initial begin
    test_reset();
    test_mt();
    test_mult();
    test_div();
    test_flush();
    test_read_hazard();
    test_reset_mid();
    test_ignored_op();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
